fifo_wr_ctrl: RTL and testbench
===============================

// Module: fifo_wr_ctrl
// PURPOSE
// - Write-side controller for the TX FIFO storage array; drives its w_en/w_addr port in the w_clk domain.
// - Owns the binary and Gray write pointers, and double-flop synchronises the read-domain Gray pointer.
// - Generates full, fill level and a sticky overflow error. Upstream pushes one NBYTES word per accepted cycle.
// PARAMETERS
// - FIFO_DEPTH     `TX_DEPTH (16)  number of entries; power of two, >=4
// - ADDR_W         $clog2(FIFO_DEPTH)  storage address width (localparam)
// - ALMOST_FULL_TH 2   almost_full asserts when free entries <= this value; legal range 1..FIFO_DEPTH-1
// PORTS
// - w_clk        in   1         write clock
// - rst          in   1         asynchronous, active-low reset
// - wr_req       in   1         upstream push request; data sits on the storage w_data bus in the same cycle
// - rd_ptr_gray  in   ADDR_W+1  read pointer from the read domain, Gray coded (asynchronous)
// - ovf_clr      in   1         clears wr_ovf
// - w_en         out  1         storage write enable
// - w_addr       out  ADDR_W    storage write address
// - wr_ptr_gray  out  ADDR_W+1  registered Gray write pointer, to the read-domain synchroniser
// - full         out  1         FIFO full; a push is refused while this is high
// - w_level      out  ADDR_W+1  occupancy as seen from the write domain, range 0..FIFO_DEPTH
// - almost_full  out  1         present only with TX_ALMOST_FULL_EN
// - wr_ovf       out  1         sticky: set when a push is attempted while full
// BEHAVIOUR
// - Reset (rst low, asynchronous):
//   - wbin, wgray, sync1 and sync2 all clear to 0.
//   - full=0, wr_ovf=0, w_level=0, almost_full=0; w_en=0 once wr_req is low.
// - Accept rule: w_en = wr_req & ~full (combinational); w_addr = wbin[ADDR_W-1:0].
//   - On a w_en rising edge, the storage captures w_data and wbin increments by 1.
//   - Write latency into storage is 1 w_clk edge.
// - Pointers:
//   - wbin is ADDR_W+1 bits and wraps modulo 2*FIFO_DEPTH; the MSB is the lap bit.
//   - wgray = wbin_next ^ (wbin_next>>1), registered; wr_ptr_gray = wgray.
// - Sync: rd_ptr_gray -> sync1 -> sync2, two w_clk flops with no logic between them.
//   - rbin_s is the Gray-to-binary conversion of sync2.
// - Full (registered):
//   - full <= (gray(wbin_next) == {~sync2[ADDR_W:ADDR_W-1], sync2[ADDR_W-2:0]}).
//   - full asserts on the same edge that accepts the FIFO_DEPTH-th outstanding word.
//   - A read-pointer advance deasserts full no earlier than the 3rd w_clk edge after rd_ptr_gray changes. This is a pessimistic, safe delay.
// - Level: w_level = wbin - rbin_s, modulo 2^(ADDR_W+1).
//   - Never exceeds FIFO_DEPTH, and never underflows, because the synced read pointer lags the true one.
// - Overflow: wr_req & full sets wr_ovf on that edge.
//   - ovf_clr clears it; if set and clear occur in the same cycle, set wins.
//   - A refused push leaves the pointers and the storage unchanged.
// - Wrap-around: address 15->0 at FIFO_DEPTH=16 needs no special case; the lap bit toggles.
// - Simultaneous push and read-pointer change: both take effect independently. The full comparison uses wbin_next and the current sync2.
// - Reset mid-operation: all state returns to the reset values immediately.
//   - Storage contents are not this block's concern.
//   - The read domain must be reset in the same window.
// CONFIGURATION
// - TX_ALMOST_FULL_EN defined:
//   - almost_full <= (FIFO_DEPTH - level_next) <= ALMOST_FULL_TH, registered.
//   - It is a hint only; the accept rule is unchanged.
// - TX_ALMOST_FULL_EN undefined: the almost_full port and its logic are absent.
// TESTING
// - Reset, then 16 consecutive pushes with rd_ptr_gray=0:
//   - w_addr steps 0..15, with one w_en per push.
//   - full rises on the edge accepting push 16; w_level=16.
// - Full state, wr_req=1 held 3 cycles:
//   - w_en=0 throughout; wbin is unchanged; wr_ovf=1 and stays 1 until an ovf_clr pulse, then 0.
// - Full FIFO, rd_ptr_gray steps 0->1 (Gray 00001):
//   - full stays 1 for 2 edges and is 0 after the 3rd edge; w_level=15.
//   - The next push writes w_addr=0 with lap bit 1; wr_ptr_gray=5'b11000.
// - Push/pop streaming across 40 words with a read pointer trailing by 4:
//   - w_addr wraps 15->0 twice; full never asserts; wr_ptr_gray changes by 1 bit per push.
// - Assert rst low mid-stream at w_level=9:
//   - full=0, w_level=0, w_addr=0 and wr_ovf=0 at once, with no clock edge needed.
// - TX_ALMOST_FULL_EN with ALMOST_FULL_TH=2:
//   - almost_full rises after push 14 (level 14), stays 1 at levels 15 and 16, and falls when level returns to 13.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller for the TX FIFO storage array (w_clk domain).
// Optional almost_full hint is built only when TX_ALMOST_FULL_EN is defined; TX_DEPTH sets the default depth.
`ifndef TX_DEPTH
`define TX_DEPTH 16
`endif

module fifo_wr_ctrl #(
  parameter int FIFO_DEPTH     = `TX_DEPTH,
  parameter int ALMOST_FULL_TH = 2
) (
  input  logic                          w_clk,
  input  logic                          rst,
  input  logic                          wr_req,
  input  logic [$clog2(FIFO_DEPTH):0]   rd_ptr_gray,
  input  logic                          ovf_clr,
  output logic                          w_en,
  output logic [$clog2(FIFO_DEPTH)-1:0] w_addr,
  output logic [$clog2(FIFO_DEPTH):0]   wr_ptr_gray,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   w_level,
`ifdef TX_ALMOST_FULL_EN
  output logic                          almost_full,
`endif
  output logic                          wr_ovf
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);

  function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
    logic [ADDR_W:0] b;
    b = '0;
    b[ADDR_W] = g[ADDR_W];
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_W:0] r_wbin;
  logic [ADDR_W:0] r_wgray;
  logic [ADDR_W:0] r_sync1;
  logic [ADDR_W:0] r_sync2;
  logic            r_full;
  logic            r_ovf;

  logic            w_push;
  logic [ADDR_W:0] w_wbin_next;
  logic [ADDR_W:0] w_wgray_next;
  logic [ADDR_W:0] w_rbin_s;
  logic [ADDR_W:0] w_full_cmp;

  assign w_push       = wr_req & ~r_full;
  assign w_wbin_next  = r_wbin + {{ADDR_W{1'b0}}, w_push};
  assign w_wgray_next = bin2gray(w_wbin_next);
  assign w_rbin_s     = gray2bin(r_sync2);
  // Read pointer one full lap behind: top two Gray bits inverted, rest equal.
  assign w_full_cmp   = {~r_sync2[ADDR_W:ADDR_W-1], r_sync2[ADDR_W-2:0]};

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_wbin  <= '0;
      r_wgray <= '0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_wgray <= w_wgray_next;
    end
  end

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= rd_ptr_gray;
      r_sync2 <= r_sync1;
    end
  end

  // Overflow set takes priority over a same-cycle clear.
  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_full <= (w_wgray_next == w_full_cmp);
      r_ovf  <= (wr_req & r_full) | (r_ovf & ~ovf_clr);
    end
  end

`ifdef TX_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] TH_V    = (ADDR_W + 1)'(ALMOST_FULL_TH);

  logic            r_af;
  logic [ADDR_W:0] w_level_next;
  logic [ADDR_W:0] w_free_next;

  assign w_level_next = w_wbin_next - w_rbin_s;
  assign w_free_next  = DEPTH_V - w_level_next;

  always_ff @(posedge w_clk or negedge rst) begin
    if (!rst) begin
      r_af <= 1'b0;
    end else begin
      r_af <= (w_free_next <= TH_V);
    end
  end

  assign almost_full = r_af;
`endif

  assign w_en        = w_push;
  assign w_addr      = r_wbin[ADDR_W-1:0];
  assign wr_ptr_gray = r_wgray;
  assign full        = r_full;
  assign w_level     = r_wbin - w_rbin_s;
  assign wr_ovf      = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: a count-based model queues per-cycle expectations, a monitor compares.
module tb_fifo_wr_ctrl;
  localparam int D  = 16;
  localparam int AW = 4;
  localparam int TH = 2;

  logic          w_clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AW:0]   rd_ptr_gray;
  logic          ovf_clr;
  logic          w_en;
  logic [AW-1:0] w_addr;
  logic [AW:0]   wr_ptr_gray;
  logic          full;
  logic [AW:0]   w_level;
  logic          almost_full;
  logic          wr_ovf;

  always #5 w_clk = ~w_clk;

  fifo_wr_ctrl dut (
    .w_clk       (w_clk),
    .rst         (rst),
    .wr_req      (wr_req),
    .rd_ptr_gray (rd_ptr_gray),
    .ovf_clr     (ovf_clr),
    .w_en        (w_en),
    .w_addr      (w_addr),
    .wr_ptr_gray (wr_ptr_gray),
    .full        (full),
    .w_level     (w_level),
`ifdef TX_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .wr_ovf      (wr_ovf)
  );

`ifndef TX_ALMOST_FULL_EN
  assign almost_full = 1'b0;
`endif

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          full;
    logic [AW:0]   lvl;
    logic          ovf;
    logic [AW:0]   g;
    logic          af;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: counts of accepted writes and of reads, plus read counts of the two previous cycles
  int   wcnt, rcnt, rd1, rd2;
  logic full_m, ovf_m, af_m;

  function automatic logic [AW:0] gray(input int n);
    logic [AW:0] b;
    b = (AW + 1)'(n % (2 * D));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    wcnt = 0; rcnt = 0; rd1 = 0; rd2 = 0;
    full_m = 1'b0; ovf_m = 1'b0; af_m = 1'b0;
  endtask

  task automatic cycle(input logic req, input logic clr, input logic adv);
    exp_t e;
    int   wn;
    logic full_old;
    @(posedge w_clk);
    #1;
    wr_req  = req;
    ovf_clr = clr;
    if (adv && rcnt < wcnt) rcnt++;
    rd_ptr_gray = gray(rcnt);
    e.en   = req & ~full_m;
    e.addr = AW'(wcnt % D);
    e.full = full_m;
    e.lvl  = (AW + 1)'(wcnt - rd2);
    e.ovf  = ovf_m;
    e.g    = gray(wcnt);
    e.af   = af_m;
    exp_q.push_back(e);
    full_old = full_m;
    wn       = wcnt + (e.en ? 1 : 0);
    full_m   = ((wn - rd2) == D);
    ovf_m    = (req & full_old) | (ovf_m & ~clr);
    af_m     = ((D - (wn - rd2)) <= TH);
    rd2  = rd1;
    rd1  = rcnt;
    wcnt = wn;
  endtask

  task automatic do_reset(input logic check);
    @(negedge w_clk);
    #1;
    wr_req  = 1'b0;
    ovf_clr = 1'b0;
    rst     = 1'b0;
    #1;
    if (check) begin
      chk("rst_full", full, 0);
      chk("rst_level", w_level, 0);
      chk("rst_addr", w_addr, 0);
      chk("rst_ovf", wr_ovf, 0);
      chk("rst_wen", w_en, 0);
    end
    rd_ptr_gray = '0;
    model_reset();
    @(posedge w_clk);
    @(negedge w_clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge w_clk);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("sb_w_en", w_en, me.en);
        if (me.en) chk("sb_w_addr", w_addr, me.addr);
        chk("sb_full", full, me.full);
        chk("sb_level", w_level, me.lvl);
        chk("sb_ovf", wr_ovf, me.ovf);
        chk("sb_gray", wr_ptr_gray, me.g);
`ifdef TX_ALMOST_FULL_EN
        chk("sb_almost_full", almost_full, me.af);
`endif
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [AW:0]   prev_g;
    logic [AW-1:0] prev_a;
    int            wraps;
    rst         = 1'b0;
    wr_req      = 1'b0;
    ovf_clr     = 1'b0;
    rd_ptr_gray = '0;
    model_reset();
    #1;
    chk("init_full", full, 0);
    chk("init_level", w_level, 0);
    chk("init_ovf", wr_ovf, 0);
    chk("init_gray", wr_ptr_gray, 0);
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    #1;
    rst = 1'b1;

    // Fill to 16 with the read pointer parked at 0
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("fill_full", full, 1);
    chk("fill_level", w_level, 16);
    chk("fill_gray", wr_ptr_gray, 5'b11000);

    // Pushes refused while full; overflow is sticky until cleared
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("ovf_set", wr_ovf, 1);
    chk("ovf_level", w_level, 16);
    chk("ovf_gray", wr_ptr_gray, 5'b11000);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("ovf_clr", wr_ovf, 0);

    // One read step: full must hold for two edges and drop after the third
    cycle(1'b0, 1'b0, 1'b1);
    @(negedge w_clk); #1;
    chk("rd_e0_full", full, 1);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("rd_e1_full", full, 1);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("rd_e2_full", full, 1);
    chk("rd_e2_level", w_level, 15);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("rd_e3_full", full, 0);
    cycle(1'b1, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("lap_wen", w_en, 1);
    chk("lap_addr", w_addr, 0);
    chk("lap_gray", wr_ptr_gray, 5'b11000);

    // Streaming 40 words with the reader trailing by about 4
    do_reset(1'b0);
    prev_g = wr_ptr_gray;
    prev_a = w_addr;
    wraps  = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'b0, (wcnt - rcnt) >= 4);
      @(negedge w_clk); #1;
      chk("stream_full", full, 0);
      if (i > 0) chk("stream_gray_1bit", $countones(wr_ptr_gray ^ prev_g), 1);
      if (prev_a == AW'(D - 1) && w_addr == '0 && w_en) wraps++;
      prev_g = wr_ptr_gray;
      prev_a = w_addr;
    end
    chk("stream_wraps", wraps, 2);

    // Asynchronous reset in the middle of traffic at level 9
    do_reset(1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("mid_level", w_level, 9);
    do_reset(1'b1);

`ifdef TX_ALMOST_FULL_EN
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("af_l13", almost_full, 0);
    for (int i = 14; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      @(negedge w_clk); #1;
      chk("af_level", w_level, i);
      chk("af_high", almost_full, 1);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0);
    @(negedge w_clk); #1;
    chk("af_back_level", w_level, 13);
    chk("af_low", almost_full, 0);
    do_reset(1'b0);
`endif

    // Randomised traffic, reader slightly slower than writer so full and overflow occur
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 4);
    end
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 8);
    end

    repeat (3) @(negedge w_clk);
    #1;
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
